// File: rtl/vector_cordic_atan2.sv
// Vectoring-mode CORDIC: (X, Y) -> Q16.16 phase and magnitude.
// One micro-rotation per enabled clock, start/busy/done handshake.
module vector_cordic_atan2 #(
    parameter int ITER  = 16,
    parameter int W     = 32,
    parameter int GUARD = 2
) (
    input  logic                Sys_clk,
    input  logic                Vec_rst,
    input  logic                Vec_ce,
    input  logic                Start,
    input  logic [W-1:0]        X,
    input  logic [W-1:0]        Y,
    output logic                Busy,
    output logic                Done,
    output logic signed [W-1:0] Phase,
    output logic [W-1:0]        Mag
);
    localparam int DW = W + GUARD;
    localparam int CW = $clog2(ITER);
    localparam int PW = DW + 17;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROT   = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [DW-1:0] PI_Q  = DW'(205887);
    localparam logic signed [DW-1:0] NPI_Q = -PI_Q;
    localparam logic signed [PW-1:0] INV_K = PW'(39797);
    localparam logic signed [PW-1:0] HALF  = PW'(32768);
    localparam logic signed [PW-1:0] SAT   = PW'(64'h7FFF_FFFF);

    logic [1:0]             state;
    logic [CW-1:0]          cnt;
    logic signed [DW-1:0]   x;
    logic signed [DW-1:0]   y;
    logic signed [DW-1:0]   z;
    logic                   zero_in;

    logic signed [DW-1:0]   xe;
    logic signed [DW-1:0]   ye;
    logic signed [DW-1:0]   x_sh;
    logic signed [DW-1:0]   y_sh;
    logic signed [DW-1:0]   a_i;
    logic signed [PW-1:0]   xw;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   mag_full;
    logic signed [W-1:0]    phase_next;
    logic [W-1:0]           mag_next;

    // Rounded atan(2^-i) in Q16.16 radians
    function automatic logic signed [DW-1:0] atan_lut(input logic [CW-1:0] i);
        logic signed [DW-1:0] a;
        case (int'(i))
            0:       a = DW'(51472);
            1:       a = DW'(30386);
            2:       a = DW'(16055);
            3:       a = DW'(8150);
            4:       a = DW'(4091);
            5:       a = DW'(2047);
            6:       a = DW'(1024);
            7:       a = DW'(512);
            8:       a = DW'(256);
            9:       a = DW'(128);
            10:      a = DW'(64);
            11:      a = DW'(32);
            12:      a = DW'(16);
            13:      a = DW'(8);
            14:      a = DW'(4);
            15:      a = DW'(2);
            default: a = '0;
        endcase
        return a;
    endfunction

    assign xe   = {{GUARD{X[W-1]}}, X};
    assign ye   = {{GUARD{Y[W-1]}}, Y};
    assign x_sh = x >>> cnt;
    assign y_sh = y >>> cnt;
    assign a_i  = atan_lut(cnt);

    assign Busy = (state == S_ROT) || (state == S_SCALE);
    assign Done = (state == S_DONE);

    // Gain compensation (1/K in Q16), round half up, then clamp both outputs
    always_comb begin
        xw       = {{(PW-DW){x[DW-1]}}, x};
        prod     = xw * INV_K;
        mag_full = (prod + HALF) >>> 16;
        mag_next = mag_full[W-1:0];
        if (zero_in || mag_full < 0)
            mag_next = '0;
        else if (mag_full > SAT)
            mag_next = SAT[W-1:0];

        phase_next = z[W-1:0];
        if (zero_in)
            phase_next = '0;
        else if (z > PI_Q)
            phase_next = PI_Q[W-1:0];
        else if (z < NPI_Q)
            phase_next = NPI_Q[W-1:0];
    end

    always_ff @(posedge Sys_clk) begin
        if (Vec_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            zero_in <= 1'b0;
            Phase   <= '0;
            Mag     <= '0;
        end else if (Vec_ce) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        cnt     <= '0;
                        zero_in <= (X == '0) && (Y == '0);
                        state   <= S_ROT;
                        // Fold left half-plane into the right half-plane
                        if (!X[W-1]) begin
                            x <= xe;
                            y <= ye;
                            z <= '0;
                        end else begin
                            x <= -xe;
                            y <= -ye;
                            z <= Y[W-1] ? NPI_Q : PI_Q;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ROT: begin
                    if (!y[DW-1]) begin
                        x <= x + y_sh;
                        y <= y - x_sh;
                        z <= z + a_i;
                    end else begin
                        x <= x - y_sh;
                        y <= y + x_sh;
                        z <= z - a_i;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state <= S_SCALE;
                end
                S_SCALE: begin
                    Phase <= phase_next;
                    Mag   <= mag_next;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_cordic_atan2.sv
// Scoreboarded bench for vector_cordic_atan2 against an ideal
// atan2/hypot model with the stated accuracy bounds.
module tb_vector_cordic_atan2;
    logic        Sys_clk = 1'b0;
    logic        Vec_rst = 1'b1;
    logic        Vec_ce  = 1'b1;
    logic        Start   = 1'b0;
    logic [31:0] X       = '0;
    logic [31:0] Y       = '0;
    logic        Busy;
    logic        Done;
    logic signed [31:0] Phase;
    logic [31:0] Mag;

    typedef struct {
        int x;
        int y;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    vector_cordic_atan2 dut (
        .Sys_clk(Sys_clk),
        .Vec_rst(Vec_rst),
        .Vec_ce (Vec_ce),
        .Start  (Start),
        .X      (X),
        .Y      (Y),
        .Busy   (Busy),
        .Done   (Done),
        .Phase  (Phase),
        .Mag    (Mag)
    );

    always #5 Sys_clk = ~Sys_clk;

    always @(posedge Sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input real act,
                       input real req, input real tol);
        n_cmp++;
        if (act - req > tol || req - act > tol) begin
            n_err++;
            $display("FAIL %s: got %0.1f, want %0.1f (tol %0.1f)",
                     nm, act, req, tol);
        end
    endtask

    // Ideal reference: true atan2 and hypot of the captured pair
    task automatic check_result(input exp_t e);
        real xr, yr, ph, mt, mr, mtol;
        xr = real'(e.x);
        yr = real'(e.y);
        if (e.x == 0 && e.y == 0) begin
            chk("zero_phase", real'(Phase), 0.0, 0.0);
            chk("zero_mag", real'(Mag), 0.0, 0.0);
        end else begin
            ph = $atan2(yr, xr) * 65536.0;
            if (ph > 205887.0) ph = 205887.0;
            if (ph < -205887.0) ph = -205887.0;
            mt = $sqrt(xr * xr + yr * yr);
            mr = (mt > 2147483647.0) ? 2147483647.0 : mt;
            mtol = real'(longint'(mt) / 4096) + 8.0;
            chk("phase", real'(Phase), ph, 8.0);
            chk("mag", real'(Mag), mr, mtol);
        end
        chk("phase_range",
            (Phase > 205887 || Phase < -205887) ? 1.0 : 0.0, 0.0, 0.0);
    endtask

    // Monitor: pops on every Done, flags late or unexpected results
    always @(negedge Sys_clk) begin
        if (Done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1.0, 0.0, 0.0);
            end else begin
                me = sb.pop_front();
                chk("done_time", real'(cyc), real'(me.done_cyc), 0.0);
                check_result(me);
            end
        end else if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
            me = sb.pop_front();
            chk("done_timeout", real'(cyc), real'(me.done_cyc), 0.0);
        end
    end

    task automatic start_op(input int xi, input int yi,
                            input int extra, input bit push);
        X     = xi;
        Y     = yi;
        Start = 1'b1;
        @(posedge Sys_clk);
        #1;
        if (push) begin
            sb.push_back('{xi, yi, cyc + 17 + extra});
            chk("busy_rise", real'(Busy), 1.0, 0.0);
        end
        @(negedge Sys_clk);
        Start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge Sys_clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("idle_timeout", real'(sb.size()), 0.0, 0.0);
            sb.delete();
        end
    endtask

    task automatic run_op(input int xi, input int yi);
        wait_idle();
        start_op(xi, yi, 0, 1'b1);
    endtask

    task automatic check_zero_outs(input string nm);
        chk({nm, "_busy"}, real'(Busy), 0.0, 0.0);
        chk({nm, "_done"}, real'(Done), 0.0, 0.0);
        chk({nm, "_phase"}, real'(Phase), 0.0, 0.0);
        chk({nm, "_mag"}, real'(Mag), 0.0, 0.0);
    endtask

    initial begin
        real th;
        int xs, ys;
        longint ax, ay;

        // Reset held with random request traffic
        repeat (3) begin
            X     = $urandom;
            Y     = $urandom;
            Start = 1'($urandom);
            @(negedge Sys_clk);
            check_zero_outs("reset");
        end
        Start   = 1'b0;
        Vec_rst = 1'b0;
        @(negedge Sys_clk);

        run_op(65536, 0);
        run_op(0, 65536);
        run_op(-65536, -65536);
        run_op(-65536, 0);
        run_op(0, 0);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_op(32'h8000_0000, 32'h8000_0000);

        // Clock-enable stall in the middle of the rotations
        wait_idle();
        start_op(123456789, -987654321, 5, 1'b1);
        repeat (6) @(negedge Sys_clk);
        Vec_ce = 1'b0;
        repeat (5) @(negedge Sys_clk);
        Vec_ce = 1'b1;

        // Start while busy must be dropped
        wait_idle();
        start_op(-500000000, 300000000, 0, 1'b1);
        repeat (3) @(negedge Sys_clk);
        start_op(1000, 2000, 0, 1'b0);

        // Abort mid-operation, then a clean request
        wait_idle();
        start_op(400000000, 400000000, 0, 1'b0);
        repeat (8) @(negedge Sys_clk);
        Vec_rst = 1'b1;
        @(negedge Sys_clk);
        Vec_rst = 1'b0;
        check_zero_outs("abort");
        repeat (25) @(negedge Sys_clk);
        run_op(700000, -900000);

        // Oscillator-style sweep over (-pi, pi)
        for (int k = 0; k < 24; k++) begin
            th = -3.13 + 6.26 * real'(k) / 23.0;
            xs = int'($cos(th) * 1073741824.0);
            ys = int'($sin(th) * 1073741824.0);
            run_op(xs, ys);
        end

        // Random pairs with back-to-back and gapped requests
        for (int k = 0; k < 40; k++) begin
            do begin
                xs = $urandom;
                ys = $urandom;
                ax = (xs < 0) ? -longint'(xs) : longint'(xs);
                ay = (ys < 0) ? -longint'(ys) : longint'(ys);
            end while (ax < 64'd1048576 && ay < 64'd1048576);
            run_op(xs, ys);
            repeat ($urandom_range(0, 2)) @(negedge Sys_clk);
        end

        wait_idle();
        repeat (5) @(negedge Sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
